// File: rtl/axi_line_master.sv
// axi_line_master
// ---------------
// AXI4 master that moves one whole cache line per request. A line fill is a
// single INCR read burst of LINE_WORDS beats. A write-back is a single INCR
// write burst of LINE_WORDS beats. Only one transaction is in flight at a time.
//
// Cache side ports:
//   req_valid / req_ready  request handshake; ready is high only while idle
//   req_write              1 = write-back, 0 = line fill
//   req_addr               line address; the in-line offset bits are ignored
//   req_wline              write-back data, word 0 in the LSBs
//   rsp_valid              one-cycle completion pulse
//   rsp_rline              fill data, word 0 in the LSBs; unchanged by writes
//   rsp_err                completion error, valid with rsp_valid
// AXI side ports:
//   full AW/W/B/AR/R master channels; IDs, user, lock, cache, prot, qos and
//   region are tied to zero, and bursts are INCR with full-width beats.

module axi_line_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int USER_WIDTH = 4,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int LINE_WORDS = 4
) (
    input  logic                             ACLK,
    input  logic                             ARESET,
    // cache request / response port
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [LINE_WORDS*DATA_WIDTH-1:0] req_wline,
    output logic                             rsp_valid,
    output logic [LINE_WORDS*DATA_WIDTH-1:0] rsp_rline,
    output logic                             rsp_err,
    // AXI write address channel
    output logic [ADDR_WIDTH-1:0]            m_AWADDR,
    output logic [7:0]                       m_AWLEN,
    output logic [2:0]                       m_AWSIZE,
    output logic [1:0]                       m_AWBURST,
    output logic [ID_WIDTH-1:0]              m_AWID,
    output logic                             m_AWLOCK,
    output logic [3:0]                       m_AWCACHE,
    output logic [2:0]                       m_AWPROT,
    output logic [3:0]                       m_AWQOS,
    output logic [3:0]                       m_AWREGION,
    output logic [USER_WIDTH-1:0]            m_AWUSER,
    output logic                             m_AWVALID,
    input  logic                             m_AWREADY,
    // AXI write data channel
    output logic [DATA_WIDTH-1:0]            m_WDATA,
    output logic [STRB_WIDTH-1:0]            m_WSTRB,
    output logic                             m_WLAST,
    output logic [USER_WIDTH-1:0]            m_WUSER,
    output logic                             m_WVALID,
    input  logic                             m_WREADY,
    // AXI write response channel
    input  logic [ID_WIDTH-1:0]              m_BID,
    input  logic [1:0]                       m_BRESP,
    input  logic                             m_BVALID,
    output logic                             m_BREADY,
    // AXI read address channel
    output logic [ADDR_WIDTH-1:0]            m_ARADDR,
    output logic [7:0]                       m_ARLEN,
    output logic [2:0]                       m_ARSIZE,
    output logic [1:0]                       m_ARBURST,
    output logic [ID_WIDTH-1:0]              m_ARID,
    output logic                             m_ARLOCK,
    output logic [3:0]                       m_ARCACHE,
    output logic [2:0]                       m_ARPROT,
    output logic [3:0]                       m_ARQOS,
    output logic [3:0]                       m_ARREGION,
    output logic [USER_WIDTH-1:0]            m_ARUSER,
    output logic                             m_ARVALID,
    input  logic                             m_ARREADY,
    // AXI read data channel
    input  logic [ID_WIDTH-1:0]              m_RID,
    input  logic [DATA_WIDTH-1:0]            m_RDATA,
    input  logic [1:0]                       m_RRESP,
    input  logic                             m_RLAST,
    input  logic                             m_RVALID,
    output logic                             m_RREADY
);

    localparam int LINE_BITS = LINE_WORDS * DATA_WIDTH;
    // One extra bit so the counter can represent "past the end of the line".
    localparam int BEAT_W    = $clog2(LINE_WORDS) + 1;
    localparam int OFFS_BITS = $clog2(LINE_WORDS * STRB_WIDTH);

    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
    localparam logic [BEAT_W-1:0]     BEAT_FULL = BEAT_W'(LINE_WORDS);
    localparam logic [ADDR_WIDTH-1:0] OFFS_MASK = ADDR_WIDTH'((64'd1 << OFFS_BITS) - 64'd1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_WR,
        ST_B,
        ST_RSP
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LINE_BITS-1:0]    wline_q;
    logic [LINE_BITS-1:0]    rline_q;
    logic [BEAT_W-1:0]       beat_q;
    logic                    aw_done_q;
    logic                    w_done_q;
    logic                    err_q;
    logic                    req_ready_q;
    logic                    arvalid_q;
    logic                    awvalid_q;
    logic                    wvalid_q;
    logic                    bready_q;
    logic                    rready_q;
    logic                    rsp_valid_q;
    logic                    rsp_err_q;

    logic                    aw_hs;
    logic                    w_hs;
    logic                    w_last_hs;
    logic                    r_err_d;
    logic                    b_err_d;
    logic [DATA_WIDTH-1:0]   wdata_sel;

    // Response IDs carry no information because only one burst is ever open.
    logic unused_ids;
    assign unused_ids = ^{m_BID, m_RID};

    // Handshake decode and the error value a beat or write response would
    // leave behind. A read beat is in error on a bad RRESP, when it overruns
    // the line, or when it is the RLAST beat but not the final line word.
    always_comb begin
        aw_hs     = awvalid_q && m_AWREADY;
        w_hs      = wvalid_q && m_WREADY;
        w_last_hs = w_hs && (beat_q == LAST_BEAT);
        r_err_d   = err_q
                  | (m_RRESP != 2'b00)
                  | (beat_q >= BEAT_FULL)
                  | (m_RLAST && (beat_q != LAST_BEAT));
        b_err_d   = err_q | (m_BRESP != 2'b00);
    end

    // Write data comes straight from the latched line, indexed by the beat
    // counter, so it cannot change while the slave stalls W.
    always_comb begin
        wdata_sel = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            if (beat_q == BEAT_W'(i)) begin
                wdata_sel = wline_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Transaction sequencer. All channel valid/ready outputs are registers
    // updated alongside the state so they never glitch.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wline_q     <= '0;
            rline_q     <= '0;
            beat_q      <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            arvalid_q   <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        addr_q      <= req_addr & ~OFFS_MASK;
                        wline_q     <= req_wline;
                        err_q       <= 1'b0;
                        beat_q      <= '0;
                        aw_done_q   <= 1'b0;
                        w_done_q    <= 1'b0;
                        req_ready_q <= 1'b0;
                        if (req_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= ST_WR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= ST_AR;
                        end
                    end
                end
                ST_AR: begin
                    if (m_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_R;
                    end
                end
                ST_R: begin
                    if (m_RVALID) begin
                        err_q <= r_err_d;
                        // Beats past the end of the line are dropped; the
                        // counter parks at LINE_WORDS so it cannot wrap.
                        if (beat_q < BEAT_FULL) begin
                            for (int i = 0; i < LINE_WORDS; i++) begin
                                if (beat_q == BEAT_W'(i)) begin
                                    rline_q[i*DATA_WIDTH +: DATA_WIDTH] <= m_RDATA;
                                end
                            end
                            beat_q <= beat_q + BEAT_W'(1);
                        end
                        if (m_RLAST) begin
                            rready_q    <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= r_err_d;
                            state_q     <= ST_RSP;
                        end
                    end
                end
                ST_WR: begin
                    // AW and W run independently; whichever finishes first
                    // simply waits for the other.
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        if (beat_q == LAST_BEAT) begin
                            wvalid_q <= 1'b0;
                            w_done_q <= 1'b1;
                        end else begin
                            beat_q <= beat_q + BEAT_W'(1);
                        end
                    end
                    if ((aw_done_q || aw_hs) && (w_done_q || w_last_hs)) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_B;
                    end
                end
                ST_B: begin
                    if (m_BVALID) begin
                        bready_q    <= 1'b0;
                        err_q       <= b_err_d;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= b_err_d;
                        state_q     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rline  = rline_q;
    assign rsp_err    = rsp_err_q;

    assign m_AWADDR   = addr_q;
    assign m_AWLEN    = 8'(LINE_WORDS - 1);
    assign m_AWSIZE   = 3'($clog2(STRB_WIDTH));
    assign m_AWBURST  = 2'b01;
    assign m_AWID     = '0;
    assign m_AWLOCK   = 1'b0;
    assign m_AWCACHE  = 4'b0000;
    assign m_AWPROT   = 3'b000;
    assign m_AWQOS    = 4'b0000;
    assign m_AWREGION = 4'b0000;
    assign m_AWUSER   = '0;
    assign m_AWVALID  = awvalid_q;

    assign m_WDATA    = wdata_sel;
    assign m_WSTRB    = '1;
    assign m_WLAST    = (beat_q == LAST_BEAT);
    assign m_WUSER    = '0;
    assign m_WVALID   = wvalid_q;

    assign m_BREADY   = bready_q;

    assign m_ARADDR   = addr_q;
    assign m_ARLEN    = 8'(LINE_WORDS - 1);
    assign m_ARSIZE   = 3'($clog2(STRB_WIDTH));
    assign m_ARBURST  = 2'b01;
    assign m_ARID     = '0;
    assign m_ARLOCK   = 1'b0;
    assign m_ARCACHE  = 4'b0000;
    assign m_ARPROT   = 3'b000;
    assign m_ARQOS    = 4'b0000;
    assign m_ARREGION = 4'b0000;
    assign m_ARUSER   = '0;
    assign m_ARVALID  = arvalid_q;

    assign m_RREADY   = rready_q;

endmodule

// File: tb/tb_axi_line_master.sv
// tb_axi_line_master
// ------------------
// Directed bench for axi_line_master: a behavioural AXI slave with a small
// word memory and configurable stalls/errors, a cache-side driver, and a
// scoreboard queue of expected completions.

module tb_axi_line_master;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int IW = 1;
    localparam int UW = 4;
    localparam int SW = DW / 8;
    localparam int LW = 4;
    localparam int LB = LW * DW;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [LB-1:0] req_wline, rsp_rline;
    logic          rsp_valid, rsp_err;

    logic [AW-1:0] m_AWADDR, m_ARADDR;
    logic [7:0]    m_AWLEN, m_ARLEN;
    logic [2:0]    m_AWSIZE, m_ARSIZE, m_AWPROT, m_ARPROT;
    logic [1:0]    m_AWBURST, m_ARBURST, m_BRESP, m_RRESP;
    logic [IW-1:0] m_AWID, m_ARID, m_BID, m_RID;
    logic          m_AWLOCK, m_ARLOCK;
    logic [3:0]    m_AWCACHE, m_ARCACHE, m_AWQOS, m_ARQOS, m_AWREGION, m_ARREGION;
    logic [UW-1:0] m_AWUSER, m_ARUSER, m_WUSER;
    logic          m_AWVALID, m_AWREADY, m_ARVALID, m_ARREADY;
    logic [DW-1:0] m_WDATA, m_RDATA;
    logic [SW-1:0] m_WSTRB;
    logic          m_WLAST, m_WVALID, m_WREADY;
    logic          m_BVALID, m_BREADY;
    logic          m_RLAST, m_RVALID, m_RREADY;

    axi_line_master #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
        .USER_WIDTH(UW), .STRB_WIDTH(SW), .LINE_WORDS(LW)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wline(req_wline),
        .rsp_valid(rsp_valid), .rsp_rline(rsp_rline), .rsp_err(rsp_err),
        .m_AWADDR(m_AWADDR), .m_AWLEN(m_AWLEN), .m_AWSIZE(m_AWSIZE), .m_AWBURST(m_AWBURST),
        .m_AWID(m_AWID), .m_AWLOCK(m_AWLOCK), .m_AWCACHE(m_AWCACHE), .m_AWPROT(m_AWPROT),
        .m_AWQOS(m_AWQOS), .m_AWREGION(m_AWREGION), .m_AWUSER(m_AWUSER),
        .m_AWVALID(m_AWVALID), .m_AWREADY(m_AWREADY),
        .m_WDATA(m_WDATA), .m_WSTRB(m_WSTRB), .m_WLAST(m_WLAST), .m_WUSER(m_WUSER),
        .m_WVALID(m_WVALID), .m_WREADY(m_WREADY),
        .m_BID(m_BID), .m_BRESP(m_BRESP), .m_BVALID(m_BVALID), .m_BREADY(m_BREADY),
        .m_ARADDR(m_ARADDR), .m_ARLEN(m_ARLEN), .m_ARSIZE(m_ARSIZE), .m_ARBURST(m_ARBURST),
        .m_ARID(m_ARID), .m_ARLOCK(m_ARLOCK), .m_ARCACHE(m_ARCACHE), .m_ARPROT(m_ARPROT),
        .m_ARQOS(m_ARQOS), .m_ARREGION(m_ARREGION), .m_ARUSER(m_ARUSER),
        .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY),
        .m_RID(m_RID), .m_RDATA(m_RDATA), .m_RRESP(m_RRESP), .m_RLAST(m_RLAST),
        .m_RVALID(m_RVALID), .m_RREADY(m_RREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [LB-1:0] rline;
        logic          err;
        int            lat;
    } exp_t;

    exp_t          sbQ[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            rspPulses = 0;
    int            expPulses = 0;
    int            acceptCyc = 0;

    // slave memory, configuration and observations
    logic [DW-1:0] mem [0:1023];
    int            cfgAwDelay = 0;
    logic          cfgWToggle = 1'b0;
    logic          cfgRGap = 1'b0;
    logic [1:0]    cfgBresp = 2'b00;
    logic [1:0]    cfgRresp = 2'b00;
    int            cfgRLastAt = LW - 1;
    int            slvWCnt = 0;
    int            capWCntAtAw = -1;
    logic [AW-1:0] capArAddr, capAwAddr;
    logic [7:0]    capArLen, capAwLen;
    logic [2:0]    capArSize, capAwSize;
    logic [1:0]    capArBurst, capAwBurst;

    // Cycle counter and completion pulse counter on the active edge.
    always @(posedge ACLK) begin
        cyc <= cyc + 1;
        if (rsp_valid === 1'b1) rspPulses <= rspPulses + 1;
    end

    task automatic check(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one request and, if a completion is due, queue its expectation.
    task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr,
                                 input logic [LB-1:0] wl, input exp_t e, input bit expectRsp);
        int n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            @(posedge ACLK); #1; n++;
        end
        check("req_ready_before_req", req_ready, 1'b1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wline = wl;
        acceptCyc = cyc;
        if (expectRsp) begin
            sbQ.push_back(e);
            expPulses++;
        end
        @(posedge ACLK); #1;
        req_valid = 1'b0;
    endtask

    // Wait (bounded) for the completion pulse and compare against the queue.
    task automatic checkOutput(input string tag);
        exp_t e;
        int   n = 0;
        bit   got = 1'b0;
        while (n < 300) begin
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(posedge ACLK); #1; n++;
        end
        check({tag, "_rsp_seen"}, got, 1'b1);
        if (got && sbQ.size() > 0) begin
            e = sbQ.pop_front();
            check({tag, "_rline"}, rsp_rline, e.rline);
            check({tag, "_err"}, rsp_err, e.err);
            if (e.lat >= 0) check({tag, "_latency"}, cyc - acceptCyc, e.lat);
            @(posedge ACLK); #1;
            check({tag, "_rsp_one_cycle"}, rsp_valid, 1'b0);
            check({tag, "_ready_after"}, req_ready, 1'b1);
        end
    endtask

    // Behavioural AXI slave: handshakes are sampled on the edge, new
    // ready/valid values are driven 1 time unit later.
    initial begin : slave
        logic awHs, wHs, arHs, rHs, bHs;
        logic awGot, bPending, rActive, wTog, rTog, prevStall, prevWLast;
        logic [DW-1:0] prevWData;
        logic [AW-1:0] rAddr, awAddr;
        logic [DW-1:0] wBuf [0:LW-1];
        int awWaitCnt, rBeat;
        awGot = 0; bPending = 0; rActive = 0; wTog = 0; rTog = 0; prevStall = 0;
        prevWLast = 0; prevWData = '0; rAddr = '0; awAddr = '0; awWaitCnt = 0; rBeat = 0;
        m_AWREADY = 0; m_WREADY = 0; m_ARREADY = 0; m_BVALID = 0; m_BRESP = 0; m_BID = '0;
        m_RVALID = 0; m_RDATA = '0; m_RRESP = 0; m_RLAST = 0; m_RID = '0;
        forever begin
            @(posedge ACLK);
            awHs = m_AWVALID && m_AWREADY;
            wHs  = m_WVALID && m_WREADY;
            arHs = m_ARVALID && m_ARREADY;
            rHs  = m_RVALID && m_RREADY;
            bHs  = m_BVALID && m_BREADY;
            if (ARESET) begin
                awGot = 0; slvWCnt = 0; bPending = 0; rActive = 0; awWaitCnt = 0; prevStall = 0;
            end else begin
                if (prevStall && m_WVALID) begin
                    check("wdata_stable_in_stall", m_WDATA, prevWData);
                    check("wlast_stable_in_stall", m_WLAST, prevWLast);
                end
                prevStall = m_WVALID && !m_WREADY;
                prevWData = m_WDATA;
                prevWLast = m_WLAST;
                if (wHs) begin
                    check("wlast_on_beat", m_WLAST, slvWCnt == LW - 1);
                    check("wstrb_all_ones", m_WSTRB, {SW{1'b1}});
                    if (slvWCnt < LW) wBuf[slvWCnt] = m_WDATA;
                    slvWCnt++;
                end
                if (m_AWVALID && !m_AWREADY) awWaitCnt++;
                if (awHs) begin
                    awGot = 1; awAddr = m_AWADDR; awWaitCnt = 0;
                    capAwAddr = m_AWADDR; capAwLen = m_AWLEN; capAwSize = m_AWSIZE;
                    capAwBurst = m_AWBURST; capWCntAtAw = slvWCnt;
                end
                if (arHs) begin
                    rAddr = m_ARADDR; rActive = 1; rBeat = 0;
                    capArAddr = m_ARADDR; capArLen = m_ARLEN; capArSize = m_ARSIZE;
                    capArBurst = m_ARBURST;
                end
                if (rHs) begin
                    rBeat++;
                    if (m_RLAST) rActive = 0;
                end
                if (bHs) bPending = 0;
                if (awGot && slvWCnt == LW && !bPending) begin
                    for (int i = 0; i < LW; i++) mem[(int'(awAddr[11:2]) + i) & 1023] = wBuf[i];
                    awGot = 0; slvWCnt = 0; bPending = 1;
                end
            end
            wTog = !wTog;
            rTog = !rTog;
            #1;
            m_ARREADY = 1'b1;
            m_AWREADY = m_AWVALID && (awWaitCnt >= cfgAwDelay);
            m_WREADY  = cfgWToggle ? wTog : 1'b1;
            m_BVALID  = bPending;
            m_BRESP   = bPending ? cfgBresp : 2'b00;
            if (rActive && (!cfgRGap || rTog)) begin
                m_RVALID = 1'b1;
                m_RDATA  = mem[(int'(rAddr[11:2]) + rBeat) & 1023];
                m_RLAST  = (rBeat == cfgRLastAt);
                m_RRESP  = cfgRresp;
            end else begin
                m_RVALID = 1'b0;
                m_RDATA  = '0;
                m_RLAST  = 1'b0;
                m_RRESP  = 2'b00;
            end
        end
    end

    // Directed sequence
    initial begin
        exp_t          e;
        logic [LB-1:0] model;
        logic [LB-1:0] lineT1, lineA, lineB, lineC;
        int            n;
        lineT1 = {32'h44, 32'h33, 32'h22, 32'h11};
        lineA  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        lineB  = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        lineC  = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[32'h100 >> 2] = 32'h11; mem[32'h104 >> 2] = 32'h22;
        mem[32'h108 >> 2] = 32'h33; mem[32'h10C >> 2] = 32'h44;
        req_valid = 0; req_write = 0; req_addr = '0; req_wline = '0;
        ARESET = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        check("reset_req_ready", req_ready, 1'b1);
        check("reset_valids", {m_ARVALID, m_AWVALID, m_WVALID}, 3'b000);
        check("reset_readies", {m_BREADY, m_RREADY}, 2'b00);
        check("reset_rsp", {rsp_valid, rsp_err}, 2'b00);
        check("reset_rline", rsp_rline, '0);
        ARESET = 1'b0;
        @(posedge ACLK); #1;

        $display("[TB] t1: zero-wait line fill");
        e.rline = lineT1; e.err = 0; e.lat = 6;
        applyStimulus(1'b0, 32'h104, '0, e, 1'b1);
        checkOutput("t1");
        check("t1_araddr", capArAddr, 32'h100);
        check("t1_arlen", capArLen, 8'd3);
        check("t1_arsize", capArSize, 3'd2);
        check("t1_arburst", capArBurst, 2'b01);
        model = lineT1;

        $display("[TB] t2: write-back with AW held off");
        cfgAwDelay = 6;
        e.rline = model; e.err = 0; e.lat = -1;
        applyStimulus(1'b1, 32'h200, lineA, e, 1'b1);
        checkOutput("t2w");
        check("t2_w_before_aw", capWCntAtAw, LW);
        check("t2_awaddr", capAwAddr, 32'h200);
        check("t2_awlen_size_burst", {capAwLen, capAwSize, capAwBurst}, {8'd3, 3'd2, 2'b01});
        cfgAwDelay = 0;
        e.rline = lineA; e.err = 0; e.lat = 6;
        applyStimulus(1'b0, 32'h200, '0, e, 1'b1);
        checkOutput("t2r");
        model = lineA;

        $display("[TB] t3: W stalls and R gaps");
        cfgWToggle = 1'b1;
        e.rline = model; e.err = 0; e.lat = -1;
        applyStimulus(1'b1, 32'h300, lineB, e, 1'b1);
        checkOutput("t3w");
        cfgWToggle = 1'b0;
        cfgRGap = 1'b1;
        e.rline = lineB; e.err = 0; e.lat = -1;
        applyStimulus(1'b0, 32'h30C, '0, e, 1'b1);
        checkOutput("t3r");
        cfgRGap = 1'b0;
        model = lineB;

        $display("[TB] t4: write error then clean read");
        cfgBresp = 2'b10;
        e.rline = model; e.err = 1; e.lat = 6;
        applyStimulus(1'b1, 32'h340, lineC, e, 1'b1);
        checkOutput("t4w");
        cfgBresp = 2'b00;
        e.rline = lineT1; e.err = 0; e.lat = 6;
        applyStimulus(1'b0, 32'h100, '0, e, 1'b1);
        checkOutput("t4r");
        model = lineT1;

        $display("[TB] t5: short and long read bursts");
        cfgRLastAt = 2;
        e.rline = {model[LB-1 -: DW], 32'hA2, 32'hA1, 32'hA0}; e.err = 1; e.lat = -1;
        applyStimulus(1'b0, 32'h200, '0, e, 1'b1);
        checkOutput("t5short");
        model = e.rline;
        cfgRLastAt = 5;
        e.rline = lineT1; e.err = 1; e.lat = -1;
        applyStimulus(1'b0, 32'h100, '0, e, 1'b1);
        checkOutput("t5long");
        cfgRLastAt = LW - 1;
        model = lineT1;

        $display("[TB] t6: reset in the middle of a write burst");
        applyStimulus(1'b1, 32'h380, lineC, e, 1'b0);
        n = 0;
        while (slvWCnt < 2 && n < 50) begin
            @(posedge ACLK); #1; n++;
        end
        check("t6_two_beats_seen", slvWCnt >= 2, 1'b1);
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        check("t6_valids_cleared", {m_ARVALID, m_AWVALID, m_WVALID}, 3'b000);
        check("t6_readies_cleared", {m_BREADY, m_RREADY}, 2'b00);
        check("t6_rsp_cleared", {rsp_valid, rsp_err}, 2'b00);
        check("t6_rline_cleared", rsp_rline, '0);
        check("t6_req_ready", req_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(posedge ACLK); #1;
            check("t6_no_rsp", rsp_valid, 1'b0);
        end
        e.rline = lineT1; e.err = 0; e.lat = 6;
        applyStimulus(1'b0, 32'h100, '0, e, 1'b1);
        checkOutput("t6r");

        repeat (3) @(posedge ACLK);
        #1;
        check("rsp_pulse_count", rspPulses, expPulses);
        check("scoreboard_empty", sbQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_line_master.md
Name: axi_line_master

Overview:
- AXI4 master engine that moves one whole cache line per request: a burst read for a line fill, or a burst write for a write-back.
- It sits between a cache controller and the AXI slave memory on the coherence SoC bus, and is the initiator counterpart of the memory's slave port.
- One transaction is outstanding at a time.
- A simple valid/ready request port on the cache side returns a one-cycle response carrying read data and error status.

Parameters:
DATA_WIDTH, 32, AXI data width and word width.
ADDR_WIDTH, 32, AXI address width.
ID_WIDTH, 1, AXI ID width; IDs are driven 0.
USER_WIDTH, 4, AXI user width; user signals are driven 0.
STRB_WIDTH, DATA_WIDTH/8, write strobe width.
LINE_WORDS, 4, beats per line (power of 2, 2..16).

Ports:
ACLK  input  1  clock; all logic on the rising edge.
ARESET  input  1  synchronous, active-high reset.
req_valid  input  1  cache request valid.
req_ready  output  1  high only in IDLE.
req_write  input  1  1 = write-back, 0 = line fill.
req_addr  input  ADDR_WIDTH  line address; low log2(LINE_WORDS*STRB_WIDTH) bits are forced to 0.
req_wline  input  LINE_WORDS*DATA_WIDTH  write line; word 0 in the LSBs.
rsp_valid  output  1  one-cycle completion pulse.
rsp_rline  output  LINE_WORDS*DATA_WIDTH  fill data; word 0 in the LSBs.
rsp_err  output  1  completion error, valid with rsp_valid.
m_AWADDR / m_ARADDR  output  ADDR_WIDTH  latched, aligned line address.
m_AWLEN / m_ARLEN  output  8  constant LINE_WORDS-1.
m_AWSIZE / m_ARSIZE  output  3  constant log2(STRB_WIDTH).
m_AWBURST / m_ARBURST  output  2  constant 2'b01 (INCR).
m_AWID / m_ARID  output  ID_WIDTH  constant 0.
m_AWLOCK, m_AWCACHE, m_AWPROT, m_AWQOS, m_AWREGION, m_AWUSER, m_WUSER, and the AR equivalents  output  per AXI  all constant 0.
m_AWVALID, m_ARVALID  output  1  address valid; m_AWREADY, m_ARREADY  input  1.
m_WDATA  output  DATA_WIDTH  current write word.
m_WSTRB  output  STRB_WIDTH  all ones.
m_WLAST  output  1  high on beat LINE_WORDS-1.
m_WVALID  output  1; m_WREADY  input  1.
m_BID  input  ID_WIDTH  ignored; m_BRESP  input  2; m_BVALID  input  1; m_BREADY  output  1.
m_RID  input  ID_WIDTH  ignored; m_RDATA  input  DATA_WIDTH; m_RRESP  input  2; m_RLAST  input  1; m_RVALID  input  1; m_RREADY  output  1.

Behaviour:
- Reset values: state IDLE; req_ready 1; all m_*VALID 0; m_BREADY 0; m_RREADY 0; rsp_valid 0; rsp_err 0; rsp_rline 0; beat counter 0; aw_done 0; error flag 0.
- States: IDLE, AR, R, WR, B, RSP.
- IDLE:
  - A request is accepted on req_valid && req_ready.
  - On accept, latch the aligned address, req_write and req_wline, and clear the error flag and beat counter.
  - Next state is WR if req_write, else AR.
- AR:
  - m_ARVALID is high from the cycle after accept.
  - m_ARVALID and m_ARADDR hold until m_ARREADY; then go to R.
- R:
  - m_RREADY = 1.
  - Each m_RVALID beat writes m_RDATA into word[beat] of rsp_rline, then beat increments.
  - m_RRESP != 0 sets the error flag.
  - Beats with beat >= LINE_WORDS are discarded and set the error flag.
  - The burst ends only on a m_RLAST beat; if beat != LINE_WORDS-1 at m_RLAST, set the error flag. Then go to RSP.
- WR:
  - m_AWVALID and m_WVALID both rise in the cycle after accept.
  - AW completes independently: on m_AWREADY set aw_done and drop m_AWVALID. W beats never wait for AW, and AW never waits for W.
  - m_WDATA = latched word[beat]; m_WLAST = (beat == LINE_WORDS-1).
  - m_WDATA and m_WLAST are stable while m_WVALID && !m_WREADY.
  - On the last W handshake, drop m_WVALID.
  - Go to B once aw_done and the last W handshake have both happened, including in the same cycle.
- B:
  - m_BREADY = 1.
  - On m_BVALID, the error flag |= (m_BRESP != 0); go to RSP.
- RSP:
  - rsp_valid = 1 for exactly one cycle.
  - rsp_err = error flag.
  - rsp_rline holds new data for reads and keeps its previous contents for writes.
  - Next state IDLE.
- Error status is per transaction; it is cleared on each accept.
- Minimum read latency (zero-wait slave): accept at cycle 0, AR handshake at cycle 1, beats at cycles 2..LINE_WORDS+1, rsp_valid at LINE_WORDS+2.
- Minimum write latency: AW and first W handshake at cycle 1, last W at LINE_WORDS, B at LINE_WORDS+1, rsp_valid at LINE_WORDS+2.
- ARESET mid-transaction:
  - The burst is abandoned; all outputs take their reset values at the next edge.
  - The slave is reset in the same domain; no completion is generated.

Test Plan:
1. Read at req_addr 0x104, memory words 0x11/0x22/0x33/0x44 at 0x100..0x10C, zero-wait slave -> m_ARADDR=0x100, ARLEN=3, ARSIZE=2, ARBURST=1; rsp_rline={0x44,0x33,0x22,0x11}; rsp_err=0; rsp_valid at cycle 6.
2. Write 0x200 with words A0..A3, m_AWREADY held low 6 cycles, m_WREADY=1 -> all four W beats complete before the AW handshake; WLAST only on A3; BRESP OKAY gives rsp_err=0; a follow-up read returns A0..A3.
3. m_WREADY toggling 1/0, and RVALID gaps every other cycle -> WDATA/WLAST stable while stalled; beat order preserved; read data exact.
4. BRESP=2'b10 -> rsp_err=1; the next read with RRESP OKAY -> rsp_err=0.
5. Read with m_RLAST on beat 2 of 4 -> rsp_err=1 with one rsp_valid pulse; req_ready=1 the following cycle.
6. ARESET pulsed after 2 W beats -> next cycle all VALIDs 0 and rsp_valid never asserted; a subsequent read completes correctly.
